vred_accum_unit: RTL and testbench
==================================

# vred_accum_unit

Multi-beat, parametrised vector reduction unit for the vALU. It streams a vector register group in as DATA_WIDTH-bit beats and accumulates element-wise under a per-element mask. It then folds the lanes to one scalar over successive cycles, combines that with the scalar seed (vs1[0]), and returns the result over a valid/ready handshake. It generalises the single-beat sum/min/max reduction to arbitrary width, multi-beat groups, masking, unsigned min/max and logical reductions.

## Interface
- DATA_WIDTH, 64, beat width; power of two, 64..512
- SEW_WIDTH, 2, element-width select width
- OP_WIDTH, 3, reduction op select width
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid & in_ready
- in_data  input  DATA_WIDTH  packed elements, element 0 in LSBs
- in_mask  input  DATA_WIDTH/8  element j active iff in_mask[j]; only the low DATA_WIDTH/SEW bits are used
- in_first  input  1  first beat of a group; op, sew and seed are sampled on this beat
- in_last  input  1  final beat of the group
- in_seed  input  64  scalar seed; low SEW bits are used
- sew  input  SEW_WIDTH  0=8, 1=16, 2=32, 3=64 bits
- op  input  OP_WIDTH  0 sum, 1 and, 2 or, 3 xor, 4 minu, 5 min, 6 maxu, 7 max
- out_valid  output  1  result valid
- out_ready  input  1  result consumed
- out_data  output  64  result, zero-extended from SEW
- busy  output  1  state != IDLE

## Operation
- States: IDLE, ACCUM, FOLD, OUT.
- Masked-off elements are replaced by the op identity:
  - sum/or/xor/maxu: 0
  - and/minu: all-ones
  - max: signed minimum
  - min: signed maximum
- Arithmetic is lane-wise at SEW. Sum wraps modulo 2^SEW. No carries cross lanes.
- IDLE: in_ready=1. A beat without in_first is dropped.
  - A beat with in_first latches op, sew and seed, and sets acc = masked in_data.
  - Next state is FOLD if in_last is also set, otherwise ACCUM.
- ACCUM: in_ready=1.
  - Each accepted beat does acc = acc OP masked in_data.
  - in_first restarts the group: op, sew and seed are re-latched and acc = masked in_data.
  - in_last goes to FOLD.
- FOLD: in_ready=0. Lane count L = DATA_WIDTH/SEW; F = log2(L).
  - Each cycle, lane i = lane i OP lane i+L/2, and L halves.
  - After F cycles, one further cycle computes res = seed OP lane0. The state then goes to OUT.
- OUT: out_valid=1, out_data = res, in_ready=0.
  - On out_ready the state returns to IDLE, with out_valid low the next cycle.
  - out_data holds its value until the next result.
- All elements masked gives res = seed.
- Reset (rst low), asynchronously: state=IDLE, acc=0, in_ready=0, out_valid=0, out_data=0, busy=0. in_ready rises on the first clock after reset release. A reset mid-group discards the group.

## Timing
- The last beat is accepted at edge T. FOLD occupies cycles T+1..T+F+1, and out_valid is high from cycle T+F+2.
- Example: DATA_WIDTH=64, sew=0 gives F=3, so out_valid is at T+5. sew=3 gives F=0, so out_valid is at T+2.
- Throughput is 1 beat/cycle in IDLE/ACCUM. No beat is accepted during FOLD or OUT.
- out_valid and out_data are stable while out_ready=0.
- All outputs are registered except in_ready and busy, which decode state.

## Structure
- Package vred_pkg holds:
  - op encodings
  - state enum
  - identity-value function (op, sew)
  - SEW-to-lane-count function
- Sub-module vred_lane_op: combinational DATA_WIDTH-wide lane-wise OP at a given sew. It is instantiated once for accumulation and once for fold; the fold instance also does the seed combine with a zero-padded operand.

## Test plan
- DATA_WIDTH=64, sew=0, sum, single beat (first & last): data 0x0807060504030201, mask 0xFF, seed 0x10 -> out_data 0x34, out_valid exactly 5 cycles after acceptance.
- sew=2, max, two beats: 0x80000000_00000005 then 0x7FFFFFFF_FFFFFFFF, seed 0xFFFFFFF0 -> 0x7FFFFFFF. Same stimulus with maxu -> 0xFFFFFFFF.
- sew=1, and, mask 0x0 on every beat, seed 0x1234 -> 0x1234.
- sew=0, sum, data 0xFFFFFFFFFFFFFFFF, mask 0xFF, seed 0x01 -> 0xF9 (wrap).
- Back-pressure: out_ready held low 3 cycles -> out_valid and out_data stable, in_ready=0 throughout. After the handshake -> IDLE, in_ready=1.
- Two cases:
  - rst pulsed low mid-ACCUM -> all outputs 0 immediately; the next group's result is unaffected by the old acc.
  - in_first asserted mid-ACCUM -> result reflects only the new group.

Source files
------------

// File: rtl/vred_pkg.sv
// Shared encodings and helpers for the vector reduction accumulator.
package vred_pkg;

   localparam int unsigned ELEM_MAX_W = 64;

   typedef enum logic [2:0] {
      OP_SUM  = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_MINU = 3'd4,
      OP_MIN  = 3'd5,
      OP_MAXU = 3'd6,
      OP_MAX  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_FOLD  = 2'd2,
      S_OUT   = 2'd3
   } state_e;

   // All-ones mask covering one element at the given element width.
   function automatic logic [ELEM_MAX_W-1:0] sew_mask(input logic [1:0] sew);
      logic [ELEM_MAX_W-1:0] m;
      case (sew)
         2'd0:    m = 64'h0000_0000_0000_00FF;
         2'd1:    m = 64'h0000_0000_0000_FFFF;
         2'd2:    m = 64'h0000_0000_FFFF_FFFF;
         default: m = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      return m;
   endfunction

   // Identity element of an op at the given width, zero-extended to 64 bits.
   function automatic logic [ELEM_MAX_W-1:0] identity(input logic [2:0] op, input logic [1:0] sew);
      logic [ELEM_MAX_W-1:0] m;
      logic [ELEM_MAX_W-1:0] msb;
      logic [ELEM_MAX_W-1:0] id;
      m   = sew_mask(sew);
      msb = m ^ (m >> 1);
      case (op_e'(op))
         OP_AND, OP_MINU: id = m;
         OP_MAX:          id = msb;
         OP_MIN:          id = m ^ msb;
         default:         id = '0;
      endcase
      return id;
   endfunction

   // Number of elements held in a dw-bit beat at the given element width.
   function automatic int unsigned lane_count(input int unsigned dw, input logic [1:0] sew);
      return dw >> (32'(sew) + 32'd3);
   endfunction

endpackage

// File: rtl/vred_lane_op.sv
// Combinational lane-wise reduction op across a full beat at a selectable element width.
module vred_lane_op
   import vred_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned SEW_WIDTH  = 2,
   parameter int unsigned OP_WIDTH   = 3
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [SEW_WIDTH-1:0]  i_sew,
   input  logic [OP_WIDTH-1:0]   i_op,
   output logic [DATA_WIDTH-1:0] o_y
);

   for (genvar s = 0; s < 4; s++) begin : g_sew
      localparam int unsigned EW = 8 << s;
      localparam int unsigned NL = DATA_WIDTH / EW;
      logic [DATA_WIDTH-1:0] w_res;

      for (genvar i = 0; i < NL; i++) begin : g_lane
         logic [EW-1:0] w_a;
         logic [EW-1:0] w_b;
         logic [EW-1:0] w_y;

         assign w_a = i_a[i*EW +: EW];
         assign w_b = i_b[i*EW +: EW];

         // One element of the selected op; sum wraps within the lane.
         always_comb begin
            case (op_e'(i_op))
               OP_SUM:  w_y = w_a + w_b;
               OP_AND:  w_y = w_a & w_b;
               OP_OR:   w_y = w_a | w_b;
               OP_XOR:  w_y = w_a ^ w_b;
               OP_MINU: w_y = (w_a < w_b) ? w_a : w_b;
               OP_MIN:  w_y = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
               OP_MAXU: w_y = (w_a > w_b) ? w_a : w_b;
               default: w_y = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
            endcase
         end

         assign w_res[i*EW +: EW] = w_y;
      end
   end

   // Pick the result computed at the requested element width.
   always_comb begin
      case (i_sew)
         2'd0:    o_y = g_sew[0].w_res;
         2'd1:    o_y = g_sew[1].w_res;
         2'd2:    o_y = g_sew[2].w_res;
         default: o_y = g_sew[3].w_res;
      endcase
   end

endmodule

// File: rtl/vred_accum_unit.sv
// Multi-beat masked vector reduction: accumulate beats, fold lanes, combine with seed.
module vred_accum_unit
   import vred_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned SEW_WIDTH  = 2,
   parameter int unsigned OP_WIDTH   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [DATA_WIDTH/8-1:0] in_mask,
   input  logic                    in_first,
   input  logic                    in_last,
   input  logic [63:0]             in_seed,
   input  logic [SEW_WIDTH-1:0]    sew,
   input  logic [OP_WIDTH-1:0]     op,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [63:0]             out_data,
   output logic                    busy
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned LANE_W = $clog2(NBYTES) + 1;

   state_e                r_state;
   logic                  r_armed;
   logic [OP_WIDTH-1:0]   r_op;
   logic [SEW_WIDTH-1:0]  r_sew;
   logic [63:0]           r_seed;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [LANE_W-1:0]     r_lanes;
   logic                  r_out_valid;
   logic [63:0]           r_out_data;

   logic                  w_accept;
   logic [OP_WIDTH-1:0]   w_cur_op;
   logic [SEW_WIDTH-1:0]  w_cur_sew;
   logic [63:0]           w_id;
   logic [DATA_WIDTH-1:0] w_masked;
   logic [DATA_WIDTH-1:0] w_acc_y;
   logic                  w_seed_step;
   int unsigned           w_shamt;
   logic [DATA_WIDTH-1:0] w_fold_a;
   logic [DATA_WIDTH-1:0] w_fold_b;
   logic [DATA_WIDTH-1:0] w_fold_y;

   // in_ready stays low until the first clock after reset release.
   assign in_ready  = r_armed && ((r_state == S_IDLE) || (r_state == S_ACCUM));
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign w_accept  = in_valid && in_ready;

   // A first beat carries its own op/sew, so mask it with those rather than the latched ones.
   assign w_cur_op  = in_first ? op  : r_op;
   assign w_cur_sew = in_first ? sew : r_sew;
   assign w_id      = identity(3'(w_cur_op), 2'(w_cur_sew));

   for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      logic       w_act;
      logic [7:0] w_idb;

      // Map this byte to its element's mask bit and its slice of the identity value.
      always_comb begin
         w_act = in_mask[b];
         w_idb = w_id[7:0];
         case (w_cur_sew)
            2'd1: begin
               w_act = in_mask[b/2];
               w_idb = w_id[(b%2)*8 +: 8];
            end
            2'd2: begin
               w_act = in_mask[b/4];
               w_idb = w_id[(b%4)*8 +: 8];
            end
            2'd3: begin
               w_act = in_mask[b/8];
               w_idb = w_id[(b%8)*8 +: 8];
            end
            default: begin
               w_act = in_mask[b];
               w_idb = w_id[7:0];
            end
         endcase
      end

      assign w_masked[b*8 +: 8] = w_act ? in_data[b*8 +: 8] : w_idb;
   end

   vred_lane_op #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEW_WIDTH  (SEW_WIDTH),
      .OP_WIDTH   (OP_WIDTH)
   ) u_acc_op (
      .i_a   (r_acc),
      .i_b   (w_masked),
      .i_sew (r_sew),
      .i_op  (r_op),
      .o_y   (w_acc_y)
   );

   // Fold pairs lane i with lane i+L/2; the final step combines lane 0 with the seed.
   assign w_seed_step = (r_lanes == LANE_W'(1));
   assign w_shamt     = (32'(r_lanes) >> 1) << (32'(r_sew) + 32'd3);
   assign w_fold_a    = w_seed_step ? DATA_WIDTH'(r_seed & sew_mask(2'(r_sew))) : r_acc;
   assign w_fold_b    = w_seed_step ? r_acc : (r_acc >> w_shamt);

   vred_lane_op #(
      .DATA_WIDTH (DATA_WIDTH),
      .SEW_WIDTH  (SEW_WIDTH),
      .OP_WIDTH   (OP_WIDTH)
   ) u_fold_op (
      .i_a   (w_fold_a),
      .i_b   (w_fold_b),
      .i_sew (r_sew),
      .i_op  (r_op),
      .o_y   (w_fold_y)
   );

   // Group control, accumulator, fold and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_armed     <= 1'b0;
         r_op        <= '0;
         r_sew       <= '0;
         r_seed      <= '0;
         r_acc       <= '0;
         r_lanes     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept && in_first) begin
                  r_op    <= op;
                  r_sew   <= sew;
                  r_seed  <= in_seed;
                  r_acc   <= w_masked;
                  r_lanes <= LANE_W'(lane_count(DATA_WIDTH, 2'(sew)));
                  r_state <= in_last ? S_FOLD : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (w_accept) begin
                  if (in_first) begin
                     r_op    <= op;
                     r_sew   <= sew;
                     r_seed  <= in_seed;
                     r_acc   <= w_masked;
                     r_lanes <= LANE_W'(lane_count(DATA_WIDTH, 2'(sew)));
                  end else begin
                     r_acc   <= w_acc_y;
                  end
                  if (in_last) begin
                     r_state <= S_FOLD;
                  end
               end
            end
            S_FOLD: begin
               if (w_seed_step) begin
                  r_out_data  <= w_fold_y[63:0] & sew_mask(2'(r_sew));
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end else begin
                  r_acc   <= w_fold_y;
                  r_lanes <= r_lanes >> 1;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vred_accum_unit.sv
// Randomised and directed bench for vred_accum_unit against an element-list reference model.
module tb_vred_accum_unit;

   localparam int unsigned DW = 64;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [DW/8-1:0] in_mask;
   logic          in_first;
   logic          in_last;
   logic [63:0]   in_seed;
   logic [1:0]    sew;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_data;
   logic          busy;

   int errors = 0;
   int checks = 0;

   logic [63:0] bd    [8];
   logic [7:0]  bm    [8];
   logic        bf    [8];
   logic        bl    [8];
   logic [2:0]  bop   [8];
   logic [1:0]  bsew  [8];
   logic [63:0] bseed [8];

   vred_accum_unit #(.DATA_WIDTH(DW), .SEW_WIDTH(2), .OP_WIDTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_seed   (in_seed),
      .sew       (sew),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] wmask(input logic [1:0] s);
      if (s == 2'd3) return 64'hFFFF_FFFF_FFFF_FFFF;
      return (64'd1 << (8 << s)) - 64'd1;
   endfunction

   function automatic longint sx(input logic [63:0] v, input int w);
      longint t;
      t = longint'(v);
      return (t <<< (64 - w)) >>> (64 - w);
   endfunction

   // Scalar op on two element values already truncated to the element width.
   function automatic logic [63:0] elem_op(input logic [2:0] o, input logic [1:0] s,
                                           input logic [63:0] a, input logic [63:0] b);
      int w;
      w = 8 << s;
      case (o)
         3'd0:    return (a + b) & wmask(s);
         3'd1:    return a & b;
         3'd2:    return a | b;
         3'd3:    return a ^ b;
         3'd4:    return (a < b) ? a : b;
         3'd5:    return (sx(a, w) < sx(b, w)) ? a : b;
         3'd6:    return (a > b) ? a : b;
         default: return (sx(a, w) > sx(b, w)) ? a : b;
      endcase
   endfunction

   // Index of the beat that starts the group actually reduced (last in_first seen).
   function automatic int group_start(input int nt);
      int st;
      st = 0;
      for (int k = 0; k < nt; k++) if (bf[k]) st = k;
      return st;
   endfunction

   // Reference: seed folded with every active element of the group, in order.
   function automatic logic [63:0] model(input int nt);
      int          st;
      int          w;
      logic [2:0]  o;
      logic [1:0]  s;
      logic [63:0] res;
      st  = group_start(nt);
      o   = bop[st];
      s   = bsew[st];
      w   = 8 << s;
      res = bseed[st] & wmask(s);
      for (int k = st; k < nt; k++)
         for (int j = 0; j < (8 >> s); j++)
            if (bm[k][j]) res = elem_op(o, s, res, (bd[k] >> (j * w)) & wmask(s));
      return res;
   endfunction

   task automatic set_beat(input int k, input logic [63:0] d, input logic [7:0] m,
                           input logic f, input logic l, input logic [2:0] o,
                           input logic [1:0] s, input logic [63:0] sd);
      bd[k] = d; bm[k] = m; bf[k] = f; bl[k] = l; bop[k] = o; bsew[k] = s; bseed[k] = sd;
   endtask

   task automatic send_beat(input int k, input string tag);
      logic done;
      done = 1'b0;
      @(negedge clk);
      in_data  = bd[k];
      in_mask  = bm[k];
      in_first = bf[k];
      in_last  = bl[k];
      op       = bop[k];
      sew      = bsew[k];
      in_seed  = bseed[k];
      in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (in_ready) begin
            @(posedge clk);
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!done) check({tag, "/accept_timeout"}, 64'd0, 64'd1);
      #1 in_valid = 1'b0;
   endtask

   // Drive nt beats, then check latency, result, back-pressure stability and the handshake.
   task automatic run_group(input int nt, input int hold, input logic use_exp,
                            input logic [63:0] exp_v, input string tag);
      logic [63:0] exp;
      int          lat;
      logic        got;
      int          f;
      exp = use_exp ? exp_v : model(nt);
      f   = 3 - int'(bsew[group_start(nt)]);
      for (int k = 0; k < nt; k++) send_beat(k, tag);
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         lat++;
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check({tag, "/out_timeout"}, 64'd0, 64'd1);
         return;
      end
      check({tag, "/latency"}, 64'(lat), 64'(f + 2));
      check({tag, "/data"}, out_data, exp);
      check({tag, "/in_ready_out"}, 64'(in_ready), 64'd0);
      check({tag, "/busy_out"}, 64'(busy), 64'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "/hold_data"}, out_data, exp);
         check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, "/post_valid"}, 64'(out_valid), 64'd0);
      check({tag, "/post_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "/post_busy"}, 64'(busy), 64'd0);
      check({tag, "/post_data"}, out_data, exp);
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      in_seed   = '0;
      sew       = '0;
      op        = '0;
      out_ready = 1'b0;

      #1;
      check("rst/out_valid", 64'(out_valid), 64'd0);
      check("rst/out_data", out_data, 64'd0);
      check("rst/in_ready", 64'(in_ready), 64'd0);
      check("rst/busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("rel/in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 check("rel/in_ready_high", 64'(in_ready), 64'd1);

      // Byte sum, single beat, held off for three cycles.
      set_beat(0, 64'h0807060504030201, 8'hFF, 1'b1, 1'b1, 3'd0, 2'd0, 64'h10);
      run_group(1, 3, 1'b1, 64'h34, "sum8");

      // Signed and unsigned max over two 32-bit beats.
      set_beat(0, 64'h80000000_00000005, 8'hFF, 1'b1, 1'b0, 3'd7, 2'd2, 64'hFFFFFFF0);
      set_beat(1, 64'h7FFFFFFF_FFFFFFFF, 8'hFF, 1'b0, 1'b1, 3'd0, 2'd0, 64'h0);
      run_group(2, 0, 1'b1, 64'h7FFFFFFF, "max32");
      bop[0] = 3'd6;
      run_group(2, 1, 1'b1, 64'hFFFFFFFF, "maxu32");

      // Fully masked AND returns the seed.
      set_beat(0, 64'h0123456789ABCDEF, 8'h00, 1'b1, 1'b0, 3'd1, 2'd1, 64'h1234);
      set_beat(1, 64'h0000000000000000, 8'h00, 1'b0, 1'b1, 3'd5, 2'd3, 64'h0);
      run_group(2, 0, 1'b1, 64'h1234, "and_masked");

      // Byte sum wraps.
      set_beat(0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 1'b1, 3'd0, 2'd0, 64'h01);
      run_group(1, 0, 1'b1, 64'hF9, "sum_wrap");

      // Reset mid-group, then an independent group.
      set_beat(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1'b0, 3'd0, 2'd1, 64'h5);
      set_beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b0, 3'd0, 2'd1, 64'h5);
      send_beat(0, "midrst");
      send_beat(1, "midrst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst/out_valid", 64'(out_valid), 64'd0);
      check("midrst/out_data", out_data, 64'd0);
      check("midrst/in_ready", 64'(in_ready), 64'd0);
      check("midrst/busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 check("midrst/in_ready_back", 64'(in_ready), 64'd1);
      set_beat(0, 64'h0000_0003_0000_0002, 8'h0F, 1'b1, 1'b1, 3'd0, 2'd2, 64'h1);
      run_group(1, 0, 1'b1, 64'h6, "after_rst");

      // Restart mid-group with a new op, width and seed.
      set_beat(0, 64'h1111_2222_3333_4444, 8'hFF, 1'b1, 1'b0, 3'd2, 2'd1, 64'hAAAA);
      set_beat(1, 64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0, 3'd2, 2'd1, 64'hAAAA);
      set_beat(2, 64'h0000_0000_0000_0A05, 8'h03, 1'b1, 1'b0, 3'd4, 2'd0, 64'h20);
      set_beat(3, 64'h0000_0000_0000_0307, 8'h01, 1'b0, 1'b1, 3'd1, 2'd3, 64'h0);
      run_group(4, 0, 1'b1, 64'h05, "restart");

      // Random groups, sometimes preceded by a dropped beat or restarted midway.
      for (int g = 0; g < 40; g++) begin
         int   n;
         int   nt;
         logic junk;
         n    = 1 + int'($urandom_range(0, 3));
         junk = ($urandom_range(0, 3) == 0);
         nt   = n + (junk ? 1 : 0);
         for (int k = 0; k < nt; k++) begin
            logic [7:0] m;
            case ($urandom_range(0, 9))
               0:       m = 8'h00;
               1, 2, 3: m = 8'hFF;
               default: m = 8'($urandom);
            endcase
            set_beat(k, {$urandom, $urandom}, m, 1'b0, (k == nt - 1),
                     3'($urandom), 2'($urandom), {$urandom, $urandom});
         end
         if (junk) begin
            bl[0] = 1'($urandom);
            bf[1] = 1'b1;
         end else begin
            bf[0] = 1'b1;
         end
         if (nt >= 3 && $urandom_range(0, 3) == 0) bf[nt - 2] = 1'b1;
         run_group(nt, int'($urandom_range(0, 2)), 1'b0, 64'd0, $sformatf("rnd%0d", g));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
